// File: rtl/uart_instr_loader_pkg.sv
// rtl/uart_instr_loader_pkg.sv - shared widths, defaults and receiver states for the UART instruction loader
package uart_instr_loader_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int IDLE_BITS_DEFAULT    = 32;
  localparam int INSTR_ADDR_W         = 8;
  localparam int INSTR_DATA_W         = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with input synchronizer, byte-valid and frame-error pulses
module uart_rx_byte
  import uart_instr_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte_tdata,
  output logic       o_byte_tvalid,
  output logic       o_frame_err,
  output logic       o_start_det,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             start_q, start_d;

  always_comb begin
    rx_meta_d = i_rx;
    rx_sync_d = rx_meta_q;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    start_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          state_d   = RX_START;
          clk_cnt_d = '0;
          start_d   = 1'b1;
        end
      end
      RX_START: begin
        // Re-check the line mid start bit; a short low pulse is dropped here.
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = RX_IDLE;
          valid_d   = rx_sync_q;
          ferr_d    = !rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= RX_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      start_q   <= start_d;
    end
  end

  assign o_byte_tdata  = shreg_q;
  assign o_byte_tvalid = valid_q;
  assign o_frame_err   = ferr_q;
  assign o_start_det   = start_q;
  assign o_busy        = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_instr_loader.sv
// rtl/uart_instr_loader.sv - assembles big-endian 16-bit words from UART bytes and writes them to instruction memory
module uart_instr_loader
  import uart_instr_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int IDLE_BITS    = IDLE_BITS_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rx,
  output logic                    o_wr_en,
  output logic [INSTR_ADDR_W-1:0] o_wr_addr,
  output logic [INSTR_DATA_W-1:0] o_wr_data,
  output logic                    o_instr_transmit_done,
  output logic [INSTR_ADDR_W-1:0] o_max_addr,
  output logic                    o_frame_err
);

  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0]       IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [INSTR_ADDR_W-1:0] ADDR_LAST = '1;

  logic [7:0] byte_tdata;
  logic       byte_tvalid, byte_ferr, start_det, rx_busy;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .o_byte_tdata (byte_tdata),
    .o_byte_tvalid(byte_tvalid),
    .o_frame_err  (byte_ferr),
    .o_start_det  (start_det),
    .o_busy       (rx_busy)
  );

  logic                    wr_en_q, wr_en_d;
  logic [INSTR_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [INSTR_DATA_W-1:0] wr_data_q, wr_data_d;
  logic [INSTR_ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [INSTR_ADDR_W-1:0] max_addr_q, max_addr_d;
  logic                    done_q, done_d;
  logic                    frame_err_q, frame_err_d;
  logic                    hi_held_q, hi_held_d;
  logic [7:0]              hi_byte_q, hi_byte_d;
  logic                    word_seen_q, word_seen_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;

  always_comb begin
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    next_addr_d = next_addr_q;
    max_addr_d  = max_addr_q;
    done_d      = done_q;
    frame_err_d = frame_err_q;
    hi_held_d   = hi_held_q;
    hi_byte_d   = hi_byte_q;
    word_seen_d = word_seen_q;
    idle_cnt_d  = idle_cnt_q;
    if (!done_q) begin
      if (byte_tvalid) begin
        if (hi_held_q) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          wr_data_d   = {hi_byte_q, byte_tdata};
          max_addr_d  = next_addr_q;
          hi_held_d   = 1'b0;
          word_seen_d = 1'b1;
          if (next_addr_q != ADDR_LAST) next_addr_d = next_addr_q + 1'b1;
        end else begin
          hi_byte_d = byte_tdata;
          hi_held_d = 1'b1;
        end
      end
      if (byte_ferr) begin
        frame_err_d = 1'b1;
        hi_held_d   = 1'b0;
      end
      // The timeout only measures quiet line time, never time spent inside a frame.
      if (start_det || rx_busy || !word_seen_q) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == IDLE_LAST) begin
        done_d    = 1'b1;
        hi_held_d = 1'b0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
      if (wr_en_q && wr_addr_q == ADDR_LAST) done_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      next_addr_q <= '0;
      max_addr_q  <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      hi_held_q   <= 1'b0;
      hi_byte_q   <= '0;
      word_seen_q <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      next_addr_q <= next_addr_d;
      max_addr_q  <= max_addr_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      hi_held_q   <= hi_held_d;
      hi_byte_q   <= hi_byte_d;
      word_seen_q <= word_seen_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign o_wr_en               = wr_en_q;
  assign o_wr_addr             = wr_addr_q;
  assign o_wr_data             = wr_data_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_addr_q;
  assign o_frame_err           = frame_err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// tb/tb_uart_instr_loader.sv - directed self-checking bench for uart_instr_loader
module tb_uart_instr_loader;

  localparam int CPB = 8;
  localparam int IDLE_BITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        done;
  logic [7:0]  max_addr;
  logic        frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  uart_instr_loader #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_rx                 (rx),
    .o_wr_en              (wr_en),
    .o_wr_addr            (wr_addr),
    .o_wr_data            (wr_data),
    .o_instr_transmit_done(done),
    .o_max_addr           (max_addr),
    .o_frame_err          (frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  addr_log[$];
  logic [15:0] data_log[$];
  int   dbl_cnt = 0;
  logic prev_wr = 1'b0;
  logic prev_ff = 1'b0;
  logic done_at_ff = 1'b1;
  logic done_after_ff = 1'b0;

  always @(negedge clk) begin
    if (prev_ff) done_after_ff = done;
    if (wr_en === 1'b1) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
      if (prev_wr) dbl_cnt++;
      if (wr_addr == 8'hFF) done_at_ff = done;
    end
    prev_ff = (wr_en === 1'b1) && (wr_addr == 8'hFF);
    prev_wr = (wr_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_wr_en"},     32'(wr_en),     32'h0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'h0);
    check({tag, "_wr_data"},   32'(wr_data),   32'h0);
    check({tag, "_done"},      32'(done),      32'h0);
    check({tag, "_max_addr"},  32'(max_addr),  32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int base;
    int errs;
    logic [15:0] w;

    do_reset("rst0");

    // Short low glitch: no byte, no write, no error, and no timeout without a word.
    base = addr_log.size();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(60);
    check("glitch_writes", 32'(addr_log.size() - base), 32'd0);
    check("glitch_ferr",   32'(frame_err), 32'h0);
    check("glitch_done",   32'(done),      32'h0);

    // Single word 0x1234.
    base = addr_log.size();
    send_word(16'h1234);
    idle(3);
    check("w1_writes", 32'(addr_log.size() - base), 32'd1);
    check("w1_addr",   32'(addr_log[base]), 32'h00);
    check("w1_data",   32'(data_log[base]), 32'h1234);
    check("w1_hold_addr", 32'(wr_addr),  32'h00);
    check("w1_hold_data", 32'(wr_data),  32'h1234);
    check("w1_max_addr",  32'(max_addr), 32'h00);
    check("w1_wr_en_low", 32'(wr_en),    32'h0);

    // Three words then idle timeout; later traffic ignored.
    do_reset("rst1");
    base = addr_log.size();
    send_word(16'hA001);
    send_word(16'hA002);
    send_word(16'hA003);
    check("t3_done_early", 32'(done), 32'h0);
    wait_done(80);
    check("t3_done",     32'(done),     32'h1);
    check("t3_max_addr", 32'(max_addr), 32'h02);
    check("t3_writes",   32'(addr_log.size() - base), 32'd3);
    check("t3_data2",    32'(data_log[base + 2]), 32'hA003);
    send_word(16'hA004);
    idle(10);
    check("t3_ignored",  32'(addr_log.size() - base), 32'd3);
    check("t3_hold_addr", 32'(wr_addr), 32'h02);
    check("t3_hold_data", 32'(wr_data), 32'hA003);

    // Bad stop bit drops the byte; a held high byte is dropped too.
    do_reset("rst2");
    base = addr_log.size();
    send_byte(8'h12, 1'b0);
    idle(16);
    send_word(16'hABCD);
    idle(3);
    check("fe_flag",   32'(frame_err), 32'h1);
    check("fe_writes", 32'(addr_log.size() - base), 32'd1);
    check("fe_addr",   32'(addr_log[base]), 32'h00);
    check("fe_data",   32'(data_log[base]), 32'hABCD);
    send_byte(8'h77, 1'b1);
    send_byte(8'h12, 1'b0);
    idle(16);
    send_word(16'hABCD);
    idle(3);
    check("fe2_writes", 32'(addr_log.size() - base), 32'd2);
    check("fe2_addr",   32'(addr_log[base + 1]), 32'h01);
    check("fe2_data",   32'(data_log[base + 1]), 32'hABCD);
    check("fe_sticky",  32'(frame_err), 32'h1);

    // Reset during bit 4 of the low byte.
    do_reset("rst3");
    base = addr_log.size();
    send_byte(8'h55, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    do_reset("rst_mid");
    check("abort_writes", 32'(addr_log.size() - base), 32'd0);
    send_word(16'hBEEF);
    idle(3);
    check("abort_next_writes", 32'(addr_log.size() - base), 32'd1);
    check("abort_next_addr",   32'(addr_log[base]), 32'h00);
    check("abort_next_data",   32'(data_log[base]), 32'hBEEF);

    // Full memory: 256 words written, 257th dropped.
    do_reset("rst4");
    base = addr_log.size();
    for (int i = 0; i < 257; i++) begin
      w = {8'(i) ^ 8'hC3, 8'(i)};
      send_word(w);
    end
    idle(10);
    check("full_writes", 32'(addr_log.size() - base), 32'd256);
    errs = 0;
    for (int k = 0; k < 256 && base + k < addr_log.size(); k++) begin
      w = {8'(k) ^ 8'hC3, 8'(k)};
      if (addr_log[base + k] !== 8'(k) || data_log[base + k] !== w) errs++;
    end
    check("full_seq_errs",   32'(errs), 32'd0);
    check("full_last_addr",  32'(wr_addr),  32'hFF);
    check("full_max_addr",   32'(max_addr), 32'hFF);
    check("full_done",       32'(done),     32'h1);
    check("full_done_at_ff", 32'(done_at_ff),    32'h0);
    check("full_done_next",  32'(done_after_ff), 32'h1);
    check("dbl_pulses",      32'(dbl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
